ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte, e.g. 0xED (set LEDs) or 0xFF (reset), to a PS/2 keyboard or mouse over the shared open-drain ps2_clk/ps2_dat pair.
- Sits beside the existing PS/2 receive shift register on the same inout lines. Runs in the CLOCK_50 domain.
- Performs the inhibit/request-to-send sequence, shifts data, odd parity and stop bits on device-generated clock edges, then checks the device ACK.

Parameters:
- INHIBIT_CYCLES, 6000: CLOCK_50 cycles ps2_clk is held low before request-to-send (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum CLOCK_50 cycles allowed between device falling edges, and from request-to-send to the first edge (15 ms).

Ports:
- CLOCK_50  input  1  system clock.
- Reset  input  1  synchronous, active-high reset. The design has one clock, and reset is synchronous and active-high.
- send  input  1  one-cycle start strobe. Sampled only in IDLE.
- data_in  input  8  byte to transmit. Captured on the accepted send.
- ps2_clk  inout  1  open-drain. Module drives 0 or 'z' only.
- ps2_dat  inout  1  open-drain. Module drives 0 or 'z' only.
- busy  output  1  high from the cycle after an accepted send until the return to IDLE.
- done  output  1  one-cycle pulse: frame sent and ACK seen.
- error  output  1  one-cycle pulse: missing ACK or timeout.

Behaviour:
- Inputs: ps2_clk and ps2_dat pass through 2-FF synchronizers. A falling edge (fe) is synced previous = 1 and synced current = 0.
- Reset: state IDLE; both lines 'z'; busy = done = error = 0; counters = 0; shift register = 0.
- Reset takes priority over everything. Reset mid-frame releases both lines at the next CLOCK_50 edge and aborts with no done or error pulse.
- Latched at the accepted send:
  - shift = {~^data_in, data_in}: odd parity, LSB sent first.
  - bitcnt = 0.
- IDLE: lines 'z'. send = 1 -> INHIBIT. send in any other state is ignored.
- INHIBIT: drive ps2_clk = 0, ps2_dat 'z'. Count INHIBIT_CYCLES cycles -> RTS.
  - ps2_clk is low for exactly INHIBIT_CYCLES cycles, starting the cycle after send.
- RTS (request-to-send / start bit):
  - Drive ps2_dat = 0, release ps2_clk. The start bit is now on the line.
  - Start the timeout counter.
  - On fe -> DATA, presenting shift[0]; bitcnt = 1.
- DATA:
  - ps2_dat = 0 when the current bit is 0, 'z' when it is 1.
  - On each fe, shift right and increment bitcnt.
  - fe 1-8 present d0..d7; fe 9 presents parity; fe 10 presents the stop bit (release ps2_dat) -> ACK.
  - Bits change only on fe; the device samples on the rising edge.
- ACK: both lines 'z'. On fe 11, sample synced ps2_dat.
  - 0 -> WAIT_IDLE.
  - 1 -> error pulse, then IDLE.
- WAIT_IDLE: wait until both synced lines are 1, then pulse done -> IDLE.
  - This state is also subject to the timeout.
- Timeout:
  - Counter clears on every fe and on entry to RTS. It is active in RTS, DATA, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES: release lines, pulse error, go to IDLE.
- busy deasserts in the same cycle done or error pulses.
- done and error are never both high.
- Counter widths: $clog2 of the respective parameter plus 1. No wrap is possible, because each counter compares and stops at its terminal value.
- bitcnt is 4 bits and is only ever 0..11.
- A glitch on ps2_clk while IDLE or INHIBIT has no effect.

Test Plan:
1. INHIBIT_CYCLES = 10, send with data_in = 0xED:
   - ps2_clk low for exactly 10 cycles, then ps2_dat = 0 and ps2_clk released.
   - Device model clocks at a 40-cycle period and captures 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - Device model ACKs low -> done pulse once; busy 1 -> 0; lines 'z'.
2. Parity sweep: 0x00 -> parity 1; 0xFF -> parity 1; 0x01 -> parity 0; 0xF4 -> parity 0. Each frame is captured exactly by the device model.
3. Device leaves ps2_dat high at fe 11 -> error pulse, no done, return to IDLE, lines 'z'.
4. TIMEOUT_CYCLES = 200, device never clocks after RTS -> error exactly 200 cycles after RTS entry, ps2_dat released. A second send then completes normally.
5. Reset asserted after fe 4 of a frame:
   - Next cycle both lines 'z', busy = 0, no done or error.
   - A following send of 0xFF completes with done.
6. send pulsed during DATA, and send asserted in the same cycle as Reset -> both ignored; exactly one frame observed on the bus.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibit, request-to-send, device-clocked frame shift and ACK check on open-drain lines.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       send,
  input  logic [7:0] data_in,
  inout  tri         ps2_clk,
  inout  tri         ps2_dat,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE} state_t;

  state_t        state;
  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [8:0]    shift;
  logic [3:0]    bitcnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          clk_oe;
  logic          dat_oe;
  logic          fe;

  assign ps2_clk = clk_oe ? 1'b0 : 1'bz;
  assign ps2_dat = dat_oe ? 1'b0 : 1'bz;

  // clk_sync[1] is the synced level, clk_sync[2] its previous value
  assign fe = clk_sync[2] & ~clk_sync[1];

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state    <= IDLE;
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
      shift    <= '0;
      bitcnt   <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      clk_oe   <= 1'b0;
      dat_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            state   <= INHIBIT;
            shift   <= {~^data_in, data_in};
            bitcnt  <= '0;
            inh_cnt <= '0;
            clk_oe  <= 1'b1;
            dat_oe  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        INHIBIT: begin
          if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            state  <= RTS;
            clk_oe <= 1'b0;
            dat_oe <= 1'b1;
            to_cnt <= '0;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        default: begin
          if (fe) begin
            to_cnt <= '0;
            case (state)
              RTS: begin
                state  <= DATA;
                dat_oe <= ~shift[0];
                bitcnt <= 4'd1;
              end
              DATA: begin
                // fe 10 releases the line for the stop bit
                if (bitcnt == 4'd9) begin
                  dat_oe <= 1'b0;
                  bitcnt <= 4'd10;
                  state  <= ACK;
                end else begin
                  shift  <= {1'b0, shift[8:1]};
                  dat_oe <= ~shift[1];
                  bitcnt <= bitcnt + 4'd1;
                end
              end
              ACK: begin
                bitcnt <= 4'd11;
                if (!dat_sync[1]) begin
                  state <= WAIT_IDLE;
                end else begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end
              default: ;
            endcase
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            clk_oe <= 1'b0;
            dat_oe <= 1'b0;
            error  <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (state == WAIT_IDLE && clk_sync[1] && dat_sync[1]) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a clocking device model
// Stimulus pushes expected outcomes; a negedge monitor pops them on every done/error pulse.
module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int TO  = 200;

  logic       CLOCK_50 = 1'b0;
  logic       Reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, done, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  wire        ps2_clk;
  wire        ps2_dat;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .send(send), .data_in(data_in),
    .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .busy(busy), .done(done), .error(error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    bit         is_err;
    bit         chk_frame;
    logic [9:0] frame;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] cap_frame = '0;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // frame is {stop, parity, d7..d0}; parity is hand-computed in the tables below
  task automatic push_exp(input bit is_err, input bit chk, input logic [7:0] d, input bit par);
    exp_t e;
    e.is_err = is_err;
    e.chk_frame = chk;
    e.frame = {1'b1, par, d};
    exp_q.push_back(e);
  endtask

  always @(negedge CLOCK_50) begin : monitor
    exp_t e;
    if (done || error) begin
      check("done_error_exclusive", {31'b0, done & error}, 32'd0);
      check("busy_low_at_end", {31'b0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_end_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("outcome_is_error", {31'b0, error}, {31'b0, e.is_err});
        if (e.chk_frame) check("captured_frame", {22'b0, cap_frame}, {22'b0, e.frame});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(posedge CLOCK_50);
    #1 data_in = d;
    send = 1'b1;
    @(posedge CLOCK_50);
    #1 send = 1'b0;
  endtask

  task automatic wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (ps2_clk && !ps2_dat) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Device clocks 11 falling edges at a 40-cycle period, sampling before each rise.
  task automatic dev_frame(input bit ack, input int stop_after, input int send_at);
    bit         ok;
    logic [9:0] bits;
    bits = '0;
    wait_rts(ok);
    check("rts_seen", {31'b0, ok}, 32'd1);
    if (!ok) return;
    tick(10);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == stop_after) begin
        tick(5);
        return;
      end
      if (i == send_at) begin
        tick(5);
        data_in = 8'h55;
        send = 1'b1;
        tick(1);
        send = 1'b0;
        tick(14);
      end else begin
        tick(20);
      end
      bits[i-1] = ps2_dat;
      dev_clk_low = 1'b0;
      tick(20);
    end
    cap_frame = bits;
    if (ack) dev_dat_low = 1'b1;
    tick(5);
    dev_clk_low = 1'b1;
    tick(20);
    dev_clk_low = 1'b0;
    tick(5);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      if (!busy) break;
    end
    check("busy_clears", {31'b0, busy}, 32'd0);
    check("clk_released", {31'b0, ps2_clk}, 32'd1);
    check("dat_released", {31'b0, ps2_dat}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         n;
    logic [7:0] sweep_d [4];
    bit         sweep_p [4];
    sweep_d = '{8'h00, 8'hFF, 8'h01, 8'hF4};
    sweep_p = '{1'b1, 1'b1, 1'b0, 1'b0};

    tick(3);
    @(negedge CLOCK_50);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_error", {31'b0, error}, 32'd0);
    check("reset_clk_z", {31'b0, ps2_clk}, 32'd1);
    check("reset_dat_z", {31'b0, ps2_dat}, 32'd1);
    @(posedge CLOCK_50);
    #1 Reset = 1'b0;
    tick(3);

    // 0xED: inhibit length, start bit, full frame and ACK
    push_exp(1'b0, 1'b1, 8'hED, 1'b1);
    send_byte(8'hED);
    @(negedge CLOCK_50);
    check("busy_after_send", {31'b0, busy}, 32'd1);
    n = 0;
    while (!ps2_clk && n < 50) begin
      n++;
      @(negedge CLOCK_50);
    end
    check("inhibit_len", n, INH);
    check("rts_dat_low", {31'b0, ps2_dat}, 32'd0);
    dev_frame(1'b1, 0, 0);
    wait_not_busy();

    for (int k = 0; k < 4; k++) begin
      push_exp(1'b0, 1'b1, sweep_d[k], sweep_p[k]);
      send_byte(sweep_d[k]);
      dev_frame(1'b1, 0, 0);
      wait_not_busy();
    end

    // device withholds ACK
    push_exp(1'b1, 1'b1, 8'h5A, 1'b1);
    send_byte(8'h5A);
    dev_frame(1'b0, 0, 0);
    wait_not_busy();

    // device never clocks after RTS
    push_exp(1'b1, 1'b0, 8'h00, 1'b0);
    send_byte(8'h99);
    wait_rts(ok);
    check("timeout_rts_seen", {31'b0, ok}, 32'd1);
    n = 0;
    while (!error && n < 400) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("timeout_len", n, TO);
    check("timeout_dat_released", {31'b0, ps2_dat}, 32'd1);
    push_exp(1'b0, 1'b1, 8'h12, 1'b1);
    send_byte(8'h12);
    dev_frame(1'b1, 0, 0);
    wait_not_busy();

    // reset after fe 4 aborts silently
    send_byte(8'h3C);
    dev_frame(1'b1, 4, 0);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    @(negedge CLOCK_50);
    check("abort_dat_z", {31'b0, ps2_dat}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    dev_clk_low = 1'b0;
    tick(2);
    check("abort_clk_z", {31'b0, ps2_clk}, 32'd1);
    push_exp(1'b0, 1'b1, 8'hFF, 1'b1);
    send_byte(8'hFF);
    dev_frame(1'b1, 0, 0);
    wait_not_busy();

    // send together with Reset, and send during DATA, are both ignored
    @(posedge CLOCK_50);
    #1 Reset = 1'b1;
    send = 1'b1;
    data_in = 8'h77;
    tick(1);
    Reset = 1'b0;
    send = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK_50);
      if (!ps2_clk || busy) n++;
    end
    check("reset_send_ignored", n, 0);
    push_exp(1'b0, 1'b1, 8'hA3, 1'b1);
    send_byte(8'hA3);
    dev_frame(1'b1, 0, 3);
    wait_not_busy();
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      if (!ps2_clk || busy) n++;
    end
    check("single_frame_only", n, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
